// File: rtl/regfile_stream_loader_pkg.sv
// -----------------------------------------------------------------------------
// regfile_stream_loader_pkg
// Shared types and constants for the register-file stream loader.
//   state_e       : loader job state (IDLE / LOAD / DRAIN)
//   DRAIN_CYCLES  : cycles spent in DRAIN after the last accepted beat
// Optional feature macro: REGFILE_STREAM_LOADER_VERIFY_EN (readback check).
// -----------------------------------------------------------------------------
package regfile_stream_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // With readback the last compare needs one more cycle before DONE.
`ifdef REGFILE_STREAM_LOADER_VERIFY_EN
  localparam logic [1:0] DRAIN_CYCLES = 2'd2;
`else
  localparam logic [1:0] DRAIN_CYCLES = 2'd1;
`endif

endpackage

// File: rtl/regfile_stream_loader_verify.sv
// -----------------------------------------------------------------------------
// regfile_stream_loader_verify
// Readback pipeline: one cycle after each write, reads the written address back
// through the register file read port and compares it with the held write data.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   we         : write enable seen by the register file this cycle
//   waddr      : write address this cycle
//   wdata      : write data this cycle
//   raddr      : read-port address (address written in the previous cycle)
//   rdata      : combinational read data for raddr
//   mismatch   : high when the readback differs from the data written
// -----------------------------------------------------------------------------
module regfile_stream_loader_verify #(
  parameter int addr_width = 5,
  parameter int data_width = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  output logic [addr_width-1:0] raddr,
  input  logic [data_width-1:0] rdata,
  output logic                  mismatch
);

  logic                  chk_q,   chk_d;
  logic [addr_width-1:0] raddr_q, raddr_d;
  logic [data_width-1:0] hold_q,  hold_d;

  // Capture each write so it can be read back on the following cycle.
  always_comb begin
    chk_d   = we;
    raddr_d = raddr_q;
    hold_d  = hold_q;
    if (we) begin
      raddr_d = waddr;
      hold_d  = wdata;
    end else begin
      raddr_d = raddr_q;
      hold_d  = hold_q;
    end
  end

  // Readback pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q   <= 1'b0;
      raddr_q <= {addr_width{1'b0}};
      hold_q  <= {data_width{1'b0}};
    end else begin
      chk_q   <= chk_d;
      raddr_q <= raddr_d;
      hold_q  <= hold_d;
    end
  end

  assign raddr    = raddr_q;
  assign mismatch = chk_q & (rdata != hold_q);

endmodule

// File: rtl/regfile_stream_loader.sv
// -----------------------------------------------------------------------------
// regfile_stream_loader
// Drains a valid/ready beat stream into a register file write port at
// sequential addresses (wrapping hi -> lo) starting from a programmable base.
// Optional feature macro: REGFILE_STREAM_LOADER_VERIFY_EN -- each write is read
// back one cycle later and a mismatch sets the sticky ERR flag.
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   START/BASE/COUNT  : job request, sampled only in IDLE
//   BUSY, DONE, ERR   : job status (DONE is a one-cycle pulse, ERR sticky)
//   S_VALID/S_DATA/S_READY : input beat stream
//   WADDR/WDATA/WE    : register file write port (registered, latency 1)
//   RADDR/RDATA       : register file read port used for readback
// -----------------------------------------------------------------------------
module regfile_stream_loader
  import regfile_stream_loader_pkg::*;
#(
  parameter int addr_width = 5,
  parameter int data_width = 64,
  parameter int lo         = 0,
  parameter int hi         = 31
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [addr_width-1:0] BASE,
  input  logic [addr_width:0]   COUNT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  input  logic                  S_VALID,
  input  logic [data_width-1:0] S_DATA,
  output logic                  S_READY,
  output logic [addr_width-1:0] WADDR,
  output logic [data_width-1:0] WDATA,
  output logic                  WE,
  output logic [addr_width-1:0] RADDR,
  input  logic [data_width-1:0] RDATA
);

  localparam logic [addr_width-1:0] LO_A     = addr_width'(lo);
  localparam logic [addr_width-1:0] HI_A     = addr_width'(hi);
  localparam logic [addr_width:0]   CNT_ZERO = {(addr_width+1){1'b0}};
  localparam logic [addr_width:0]   CNT_ONE  = (addr_width+1)'(1);

  state_e                state_q,     state_d;
  logic [addr_width-1:0] addr_q,      addr_d;
  logic [addr_width:0]   remaining_q, remaining_d;
  logic                  we_q,        we_d;
  logic [addr_width-1:0] waddr_q,     waddr_d;
  logic [data_width-1:0] wdata_q,     wdata_d;
  logic                  done_q,      done_d;
  logic                  err_q,       err_d;
  logic [1:0]            drain_q,     drain_d;

  logic                  base_ok_s;
  logic                  mismatch_s;

  assign base_ok_s = (int'(BASE) >= lo) && (int'(BASE) <= hi);

`ifdef REGFILE_STREAM_LOADER_VERIFY_EN
  regfile_stream_loader_verify #(
    .addr_width (addr_width),
    .data_width (data_width)
  ) u_verify (
    .clk      (CLK),
    .rst      (RST),
    .we       (we_q),
    .waddr    (waddr_q),
    .wdata    (wdata_q),
    .raddr    (RADDR),
    .rdata    (RDATA),
    .mismatch (mismatch_s)
  );
`else
  logic rdata_unused_s;
  assign rdata_unused_s = ^RDATA;
  assign RADDR          = {addr_width{1'b0}};
  assign mismatch_s     = 1'b0;
`endif

  // Job sequencing, address generation and the registered write port.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    err_d       = err_q | mismatch_s;
    drain_d     = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          // An accepted START clears ERR; an out-of-range base restarts at lo.
          err_d       = ~base_ok_s;
          addr_d      = base_ok_s ? BASE : LO_A;
          remaining_d = COUNT;
          if (COUNT == CNT_ZERO) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (S_VALID) begin
          we_d        = 1'b1;
          waddr_d     = addr_q;
          wdata_d     = S_DATA;
          addr_d      = (addr_q == HI_A) ? LO_A : addr_q + 1'b1;
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_CYCLES;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        // Count down until the final write (and its readback) has retired.
        if (drain_q <= 2'd1) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          drain_d = 2'd0;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= {addr_width{1'b0}};
      remaining_q <= CNT_ZERO;
      we_q        <= 1'b0;
      waddr_q     <= {addr_width{1'b0}};
      wdata_q     <= {data_width{1'b0}};
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      drain_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      drain_q     <= drain_d;
    end
  end

  assign BUSY    = (state_q != ST_IDLE);
  assign S_READY = (state_q == ST_LOAD);
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign WE      = we_q;
  assign WADDR   = waddr_q;
  assign WDATA   = wdata_q;

endmodule
